// File: rtl/sdram_sched_pkg.sv
// Shared types, command encodings and default timing for the SDRAM init/refresh scheduler.
// SDRAM_RFSH_BURST_EN selects the deep pending counter used for refresh bursts.
package sdram_sched_pkg;

    localparam int unsigned ADDR_W   = 13;
    localparam int unsigned PERIOD_W = 12;
    localparam int unsigned CNT_W    = 16;

    localparam int unsigned DEF_INIT_WAIT = 10000;
    localparam int unsigned DEF_TRP       = 2;
    localparam int unsigned DEF_TRCAR     = 7;
    localparam int unsigned DEF_TMRD      = 2;

`ifdef SDRAM_RFSH_BURST_EN
    localparam int unsigned PEND_W   = 3;
    localparam int unsigned PEND_MAX = 4;
`else
    localparam int unsigned PEND_W   = 1;
    localparam int unsigned PEND_MAX = 1;
`endif

    // {ras_n, cas_n, we_n}
    typedef enum logic [2:0] {
        CMD_MRS  = 3'b000,
        CMD_AREF = 3'b001,
        CMD_PRE  = 3'b010,
        CMD_NOP  = 3'b111
    } cmd_e;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_INIT_WAIT,
        ST_PRE,
        ST_WAIT_TRP,
        ST_AREF1,
        ST_WAIT_TRC1,
        ST_AREF2,
        ST_WAIT_TRC2,
        ST_MRS,
        ST_WAIT_MRD,
        ST_READY,
        ST_RFSH,
        ST_RFSH_WAIT
    } state_e;

    typedef struct packed {
        logic              valid;
        cmd_e              cmd;
        logic [ADDR_W-1:0] addr;
    } sdram_cmd_t;

    localparam sdram_cmd_t BUS_IDLE = '{valid: 1'b0, cmd: CMD_NOP, addr: '0};

endpackage

// File: rtl/sdram_init_rfsh_sched_if.sv
// Command bus and refresh handshake between the scheduler (master) and the main command path (slave).
interface sdram_init_rfsh_sched_if;
    import sdram_sched_pkg::*;

    logic              cmd_valid;
    logic [2:0]        cmd;
    logic [ADDR_W-1:0] cmd_addr;
    logic              init_done;
    logic              rfsh_req;
    logic              rfsh_overflow;
    logic              rfsh_gnt;

    modport master (
        output cmd_valid, cmd, cmd_addr, init_done, rfsh_req, rfsh_overflow,
        input  rfsh_gnt
    );

    modport slave (
        input  cmd_valid, cmd, cmd_addr, init_done, rfsh_req, rfsh_overflow,
        output rfsh_gnt
    );
endinterface

// File: rtl/sdram_rfsh_timer.sv
// Refresh interval timer, pending-refresh counter and sticky overflow flag.
// Pending depth is 4 with SDRAM_RFSH_BURST_EN, otherwise a single flag.
module sdram_rfsh_timer
    import sdram_sched_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    input  logic                run,
    input  logic                consume,
    input  logic [PERIOD_W-1:0] period,
    output logic                rfsh_req,
    output logic                rfsh_overflow
);

    logic [PERIOD_W-1:0] timer_q;
    logic [PERIOD_W-1:0] reload;
    logic [PEND_W-1:0]   pend_q;
    logic                expire;

    // A zero period behaves as one, so the reload value is zero either way
    assign reload = (period == '0) ? '0 : period - 1'b1;
    assign expire = run && (timer_q == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_q       <= '0;
            pend_q        <= '0;
            rfsh_overflow <= 1'b0;
        end else if (clr) begin
            timer_q <= '0;
            pend_q  <= '0;
        end else begin
            if (run) begin
                timer_q <= expire ? reload : timer_q - 1'b1;
            end
            // A simultaneous expiry and issued refresh cancel out
            if (expire && !consume) begin
                if (pend_q == PEND_W'(PEND_MAX)) begin
                    rfsh_overflow <= 1'b1;
                end else begin
                    pend_q <= pend_q + 1'b1;
                end
            end else if (consume && !expire && (pend_q != '0)) begin
                pend_q <= pend_q - 1'b1;
            end
        end
    end

    assign rfsh_req = (pend_q != '0);

endmodule

// File: rtl/sdram_init_rfsh_sched.sv
// SDRAM power-up init sequencer and periodic auto-refresh scheduler.
// Define SDRAM_RFSH_BURST_EN to allow back-to-back refreshes from a deep pending count.
module sdram_init_rfsh_sched
    import sdram_sched_pkg::*;
#(
    parameter int unsigned INIT_WAIT = DEF_INIT_WAIT,
    parameter int unsigned TRP       = DEF_TRP,
    parameter int unsigned TRCAR     = DEF_TRCAR,
    parameter int unsigned TMRD      = DEF_TMRD
) (
    input  logic                sdram_clk,
    input  logic                sdram_resetn,
    input  logic                sdram_en,
    input  logic [ADDR_W-1:0]   cfg_mode_reg,
    input  logic [PERIOD_W-1:0] cfg_rfsh_period,
    sdram_init_rfsh_sched_if.master bus
);

    // Wait-state loads: each wait state lasts load+1 cycles
    localparam logic [CNT_W-1:0] LD_INIT = CNT_W'((INIT_WAIT > 1) ? INIT_WAIT - 1 : 0);
    localparam logic [CNT_W-1:0] LD_TRP  = CNT_W'((TRP > 2) ? TRP - 2 : 0);
    localparam logic [CNT_W-1:0] LD_TRC  = CNT_W'((TRCAR > 2) ? TRCAR - 2 : 0);
    localparam logic [CNT_W-1:0] LD_MRD  = CNT_W'((TMRD > 2) ? TMRD - 2 : 0);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    sdram_cmd_t       out_q, out_d;
    logic             done_q, done_d;
    logic             rfsh_req;
    logic             rfsh_overflow;
    logic             rfsh_clr;
    logic             rfsh_consume;
    state_e           rfsh_exit;

    assign rfsh_clr     = !sdram_en;
    assign rfsh_consume = (state_q == ST_RFSH);

    sdram_rfsh_timer u_timer (
        .clk           (sdram_clk),
        .rst_n         (sdram_resetn),
        .clr           (rfsh_clr),
        .run           (done_q),
        .consume       (rfsh_consume),
        .period        (cfg_rfsh_period),
        .rfsh_req      (rfsh_req),
        .rfsh_overflow (rfsh_overflow)
    );

    always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
        if (!sdram_resetn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            out_q   <= BUS_IDLE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            done_q  <= done_d;
        end
    end

    // Next state plus the registered bus image of that state
    always_comb begin
        state_d = state_q;
        cnt_d   = (cnt_q != '0) ? cnt_q - 1'b1 : '0;
        out_d   = '{valid: 1'b1, cmd: CMD_NOP, addr: '0};
        done_d  = 1'b0;

`ifdef SDRAM_RFSH_BURST_EN
        rfsh_exit = (rfsh_req && bus.rfsh_gnt) ? ST_RFSH : ST_READY;
`else
        rfsh_exit = ST_READY;
`endif

        if (!sdram_en) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    state_d = ST_INIT_WAIT;
                    cnt_d   = LD_INIT;
                end
                ST_INIT_WAIT: if (cnt_q == '0) state_d = ST_PRE;
                ST_PRE: begin
                    state_d = (TRP > 1) ? ST_WAIT_TRP : ST_AREF1;
                    cnt_d   = LD_TRP;
                end
                ST_WAIT_TRP: if (cnt_q == '0) state_d = ST_AREF1;
                ST_AREF1: begin
                    state_d = (TRCAR > 1) ? ST_WAIT_TRC1 : ST_AREF2;
                    cnt_d   = LD_TRC;
                end
                ST_WAIT_TRC1: if (cnt_q == '0) state_d = ST_AREF2;
                ST_AREF2: begin
                    state_d = (TRCAR > 1) ? ST_WAIT_TRC2 : ST_MRS;
                    cnt_d   = LD_TRC;
                end
                ST_WAIT_TRC2: if (cnt_q == '0) state_d = ST_MRS;
                ST_MRS: begin
                    state_d = (TMRD > 1) ? ST_WAIT_MRD : ST_READY;
                    cnt_d   = LD_MRD;
                end
                ST_WAIT_MRD: if (cnt_q == '0) state_d = ST_READY;
                ST_READY: if (rfsh_req && bus.rfsh_gnt) state_d = ST_RFSH;
                ST_RFSH: begin
                    state_d = (TRCAR > 1) ? ST_RFSH_WAIT : ST_READY;
                    cnt_d   = LD_TRC;
                end
                ST_RFSH_WAIT: if (cnt_q == '0) state_d = rfsh_exit;
                default: state_d = ST_IDLE;
            endcase
        end

        unique case (state_d)
            ST_IDLE, ST_READY: out_d.valid = 1'b0;
            ST_PRE: begin
                out_d.cmd  = CMD_PRE;
                out_d.addr = ADDR_W'(13'h0400);
            end
            ST_AREF1, ST_AREF2, ST_RFSH: out_d.cmd = CMD_AREF;
            ST_MRS: begin
                out_d.cmd  = CMD_MRS;
                out_d.addr = cfg_mode_reg;
            end
            default: ;
        endcase

        done_d = (state_d inside {ST_READY, ST_RFSH, ST_RFSH_WAIT});
    end

    assign bus.cmd_valid     = out_q.valid;
    assign bus.cmd           = out_q.cmd;
    assign bus.cmd_addr      = out_q.addr;
    assign bus.init_done     = done_q;
    assign bus.rfsh_req      = rfsh_req;
    assign bus.rfsh_overflow = rfsh_overflow;

endmodule

// File: tb/tb_sdram_init_rfsh_sched.sv
// Randomized bench for sdram_init_rfsh_sched against a cycle-timeline reference model.
// Build with or without SDRAM_RFSH_BURST_EN; the model follows the same macro.
module tb_sdram_init_rfsh_sched;
    import sdram_sched_pkg::*;

    localparam int IW    = 100;
    localparam int TRP   = 2;
    localparam int TRC   = 7;
    localparam int TMRD  = 2;
    localparam int T_PRE = IW;
    localparam int T_AR1 = IW + TRP;
    localparam int T_AR2 = IW + TRP + TRC;
    localparam int T_MRS = IW + TRP + 2 * TRC;
    localparam int T_RDY = IW + TRP + 2 * TRC + TMRD;
`ifdef SDRAM_RFSH_BURST_EN
    localparam int PMAX  = 4;
    localparam bit BURST = 1'b1;
`else
    localparam int PMAX  = 1;
    localparam bit BURST = 1'b0;
`endif

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        en    = 1'b0;
    logic        gnt   = 1'b0;
    logic [12:0] mode  = '0;
    logic [11:0] period = '0;

    sdram_init_rfsh_sched_if bus();
    assign bus.rfsh_gnt = gnt;

    sdram_init_rfsh_sched #(
        .INIT_WAIT (IW),
        .TRP       (TRP),
        .TRCAR     (TRC),
        .TMRD      (TMRD)
    ) dut (
        .sdram_clk       (clk),
        .sdram_resetn    (rst_n),
        .sdram_en        (en),
        .cfg_mode_reg    (mode),
        .cfg_rfsh_period (period),
        .bus             (bus)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;
    int edge_no = 0;

    // Reference model: phase 0 idle, 1 init (m_t cycles in), 2 operational (m_rt: -1 ready, else refresh slot)
    int          m_phase, m_t, m_rt, m_pend, m_next_exp;
    bit          m_ovf, m_done;
    logic        e_valid;
    logic [2:0]  e_cmd;
    logic [12:0] e_addr;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s edge=%0d got=%0h exp=%0h", tag, edge_no, got, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_t = 0; m_rt = -1; m_pend = 0; m_next_exp = -1;
        m_ovf = 1'b0; m_done = 1'b0;
        e_valid = 1'b0; e_cmd = 3'b111; e_addr = '0;
    endtask

    task automatic model_step();
        int  old_pend;
        bit  old_done, consume, expire;
        old_pend = m_pend;
        old_done = m_done;
        consume  = (m_phase == 2) && (m_rt == 0);
        if (!en) begin
            m_phase = 0; m_done = 1'b0; m_pend = 0; m_next_exp = -1;
        end else begin
            expire = old_done && (m_next_exp < 0 || m_next_exp == edge_no);
            if (expire) m_next_exp = edge_no + ((period == 0) ? 1 : int'(period));
            if (expire && !consume) begin
                if (m_pend == PMAX) m_ovf = 1'b1;
                else m_pend++;
            end else if (consume && !expire && m_pend > 0) begin
                m_pend--;
            end
            case (m_phase)
                0: begin m_phase = 1; m_t = 0; end
                1: begin
                    if (m_t + 1 == T_RDY) begin m_phase = 2; m_rt = -1; m_done = 1'b1; end
                    else m_t++;
                end
                default: begin
                    if (m_rt < 0) begin
                        if (old_pend > 0 && gnt) m_rt = 0;
                    end else if (m_rt < TRC - 1) begin
                        m_rt++;
                    end else begin
                        m_rt = (BURST && old_pend > 0 && gnt) ? 0 : -1;
                    end
                end
            endcase
        end
        e_valid = 1'b1; e_cmd = 3'b111; e_addr = '0;
        if (m_phase == 0) e_valid = 1'b0;
        else if (m_phase == 1) begin
            if (m_t == T_PRE) begin e_cmd = 3'b010; e_addr = 13'h0400; end
            else if (m_t == T_AR1 || m_t == T_AR2) e_cmd = 3'b001;
            else if (m_t == T_MRS) begin e_cmd = 3'b000; e_addr = mode; end
        end else begin
            if (m_rt < 0) e_valid = 1'b0;
            else if (m_rt == 0) e_cmd = 3'b001;
        end
    endtask

    task automatic check_outputs();
        check_val("cmd_valid", bus.cmd_valid, e_valid);
        check_val("cmd", bus.cmd, e_cmd);
        check_val("cmd_addr", bus.cmd_addr, e_addr);
        check_val("init_done", bus.init_done, m_done);
        check_val("rfsh_req", bus.rfsh_req, m_pend != 0);
        check_val("rfsh_overflow", bus.rfsh_overflow, m_ovf);
    endtask

    task automatic tick();
        @(posedge clk);
        edge_no++;
        if (rst_n) model_step();
        else model_reset();
        #1;
        check_outputs();
    endtask

    task automatic check_reset_values();
        check_val("rst_valid", bus.cmd_valid, 1'b0);
        check_val("rst_cmd", bus.cmd, 3'b111);
        check_val("rst_addr", bus.cmd_addr, 13'h0);
        check_val("rst_done", bus.init_done, 1'b0);
        check_val("rst_req", bus.rfsh_req, 1'b0);
        check_val("rst_ovf", bus.rfsh_overflow, 1'b0);
    endtask

    initial begin
        int first_done, last_aref, n_aref, steps;
        int ptab[6];
        bit found;
        ptab = '{0, 1, 3, 7, 20, 64};
        model_reset();

        #12;
        check_reset_values();
        rst_n = 1'b1;
        tick();

        // Init sequence timing and steady 64-cycle refresh with grant tied high
        mode = 13'h0233; period = 12'd64; gnt = 1'b1; en = 1'b1;
        first_done = -1; last_aref = -1;
        for (int i = 0; i < 400; i++) begin
            tick();
            if (first_done < 0 && bus.init_done === 1'b1) first_done = i;
            if (bus.init_done === 1'b1 && bus.cmd === 3'b001) begin
                if (last_aref >= 0) check_val("rfsh_gap64", 32'(i - last_aref), 32'd64);
                last_aref = i;
            end
        end
        check_val("init_latency", 32'(first_done), 32'(T_RDY));

        // Starve the grant long enough to saturate pending and lose a refresh
        gnt = 1'b0;
        for (int i = 0; i < 300; i++) tick();
        check_val("ovf_after_starve", bus.rfsh_overflow, 1'b1);
        gnt = 1'b1; n_aref = 0; last_aref = -1;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (bus.cmd === 3'b001) begin
                if (last_aref >= 0) check_val("burst_gap", 32'(i - last_aref), 32'(TRC));
                last_aref = i;
                n_aref++;
            end
        end
        check_val("burst_count", 32'(n_aref), 32'(PMAX));

        // Async reset in the middle of a refresh recovery window
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            tick();
            if (m_phase == 2 && m_rt == 3) found = 1'b1;
        end
        check_val("reach_rfsh_wait", found, 1'b1);
        #3 rst_n = 1'b0;
        #1 check_reset_values();
        model_reset();
        tick();
        tick();
        rst_n = 1'b1;

        // Drop enable during the first tRC wait, then restart the whole sequence
        period = 12'd7;
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            tick();
            if (m_phase == 1 && m_t == T_AR1 + 3) found = 1'b1;
        end
        check_val("reach_wait_trc1", found, 1'b1);
        en = 1'b0;
        tick();
        check_val("abort_idle_valid", bus.cmd_valid, 1'b0);
        en = 1'b1;
        first_done = -1;
        steps = 0;
        for (int i = 0; i < T_RDY + 200; i++) begin
            tick();
            steps++;
            if (first_done < 0 && bus.init_done === 1'b1) first_done = i;
        end
        check_val("reinit_latency", 32'(first_done), 32'(T_RDY));

        // Random grant, period, mode and short enable drops
        for (int i = 0; i < 2500; i++) begin
            gnt  = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 199) == 0) period = 12'(ptab[$urandom_range(0, 5)]);
            mode = 13'($urandom);
            en   = ($urandom_range(0, 599) != 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
